// File: rtl/dp_step_seq.sv
// dp_step_seq: timed INC_n step sequencer for an X9C-style up/down digital potentiometer.
// Build macro DP_STORE_EN: release CS_n with INC_n high (wiper NV store), then wait STORE_CYC.
//
// state | meaning
// IDLE  | waiting for start; request clamped to the available wiper range here
// SETUP | CS_n low, U/D driven, INC_n high
// LO    | INC_n low phase; wiper moves on entry
// HI    | INC_n high phase; step counted on exit
// HOLD  | CS_n still low after the last pulse, INC_n at deselect level
// DESEL | CS_n released; INC_n returns high on the second cycle
// STORE | NV-store wait, CS_n high (DP_STORE_EN only)
// FIN   | done pulse, back to IDLE
module dp_step_seq #(
  parameter int CNT_W     = 7,
  parameter int MAX_POS   = 99,
  parameter int HALF_CYC  = 4,
  parameter int SETUP_CYC = 2,
  parameter int STORE_CYC = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic             up,
  input  logic [CNT_W-1:0] num,
  output logic             dp_cs_n,
  output logic             dp_ud,
  output logic             dp_inc_n,
  output logic             dp_busy,
  output logic             done,
  output logic             clamped,
  output logic [CNT_W-1:0] wiper_pos
);

  localparam int TMR_MAX_A = (HALF_CYC > SETUP_CYC) ? HALF_CYC : SETUP_CYC;
  localparam int TMR_MAX_B = (STORE_CYC > TMR_MAX_A) ? STORE_CYC : TMR_MAX_A;
  localparam int TMR_MAX   = (TMR_MAX_B > 2) ? TMR_MAX_B : 2;
  localparam int TMR_W     = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0] T_SETUP = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] T_HALF  = TMR_W'(HALF_CYC - 1);
  localparam logic [TMR_W-1:0] T_DESEL = TMR_W'(1);
  localparam logic [TMR_W-1:0] T_STORE = TMR_W'(STORE_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_W   = CNT_W'(MAX_POS);

`ifdef DP_STORE_EN
  localparam logic HOLD_INC = 1'b1;
`else
  localparam logic HOLD_INC = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LO, S_HI, S_HOLD, S_DESEL, S_STORE, S_FIN
  } state_t;

  state_t           state_q, state_nxt;
  logic [TMR_W-1:0] tmr_q, tmr_nxt;
  logic [CNT_W-1:0] rem_q, rem_nxt;
  logic [CNT_W-1:0] avail, eff;
  logic             dir_q, dir_nxt;
  logic             clamp_q, clamp_nxt;

  logic             cs_n_d, ud_d, inc_n_d, busy_d, done_d, clamped_d;
  logic [CNT_W-1:0] wiper_d;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      clamp_q   <= 1'b0;
      dp_cs_n   <= 1'b1;
      dp_ud     <= 1'b0;
      dp_inc_n  <= 1'b1;
      dp_busy   <= 1'b0;
      done      <= 1'b0;
      clamped   <= 1'b0;
      wiper_pos <= '0;
    end else begin
      state_q   <= state_nxt;
      tmr_q     <= tmr_nxt;
      rem_q     <= rem_nxt;
      dir_q     <= dir_nxt;
      clamp_q   <= clamp_nxt;
      dp_cs_n   <= cs_n_d;
      dp_ud     <= ud_d;
      dp_inc_n  <= inc_n_d;
      dp_busy   <= busy_d;
      done      <= done_d;
      clamped   <= clamped_d;
      wiper_pos <= wiper_d;
    end
  end

  always_comb begin
    state_nxt = state_q;
    tmr_nxt   = tmr_q;
    rem_nxt   = rem_q;
    dir_nxt   = dir_q;
    clamp_nxt = clamp_q;
    avail     = up ? (MAX_W - wiper_pos) : wiper_pos;
    eff       = (num > avail) ? avail : num;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_nxt   = up;
          rem_nxt   = eff;
          clamp_nxt = (eff != num);
          if (eff == '0) begin
            state_nxt = S_FIN;
          end else begin
            state_nxt = S_SETUP;
            tmr_nxt   = T_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (tmr_q == '0) begin
          state_nxt = S_LO;
          tmr_nxt   = T_HALF;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      S_LO: begin
        if (tmr_q == '0) begin
          state_nxt = S_HI;
          tmr_nxt   = T_HALF;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      S_HI: begin
        if (tmr_q == '0) begin
          rem_nxt = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_nxt = S_HOLD;
            tmr_nxt   = T_SETUP;
          end else begin
            state_nxt = S_LO;
            tmr_nxt   = T_HALF;
          end
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (tmr_q == '0) begin
          state_nxt = S_DESEL;
          tmr_nxt   = T_DESEL;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      S_DESEL: begin
        if (tmr_q == '0) begin
`ifdef DP_STORE_EN
          state_nxt = S_STORE;
          tmr_nxt   = T_STORE;
`else
          state_nxt = S_FIN;
`endif
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      S_STORE: begin
        if (tmr_q == '0) begin
          state_nxt = S_FIN;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the current state and registered, so pins lag the state by one edge.
  always_comb begin
    cs_n_d    = 1'b1;
    ud_d      = dp_ud;
    inc_n_d   = 1'b1;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    clamped_d = 1'b0;
    wiper_d   = wiper_pos;
    case (state_q)
      S_IDLE:  busy_d = 1'b0;
      S_SETUP: begin
        cs_n_d = 1'b0;
        ud_d   = dir_q;
      end
      S_LO: begin
        cs_n_d  = 1'b0;
        inc_n_d = 1'b0;
        if (dp_inc_n) begin
          wiper_d = dir_q ? (wiper_pos + 1'b1) : (wiper_pos - 1'b1);
        end
      end
      S_HI:    cs_n_d = 1'b0;
      S_HOLD: begin
        cs_n_d  = 1'b0;
        inc_n_d = HOLD_INC;
      end
      S_DESEL: inc_n_d = (tmr_q != '0) ? HOLD_INC : 1'b1;
      S_STORE: inc_n_d = 1'b1;
      S_FIN: begin
        busy_d    = 1'b0;
        done_d    = 1'b1;
        clamped_d = clamp_q;
      end
      default: busy_d = 1'b0;
    endcase
  end

endmodule
